bci_window_sequencer: RTL

Controller that schedules the EEG classification datapath in the PL top. It reads raw samples from a sample BRAM (1-cycle read latency) and streams overlapping windows of WIN_LEN samples, advancing by HOP, into the feature/classifier pipeline over a valid/ready handshake. It then waits for the classifier result and emits one class_label with a one-cycle done pulse per window. It stops after NUM_WINDOWS windows, and a watchdog covers a classifier that never answers.

---
 rtl/bci_window_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/bci_window_sequencer.sv
// Window sequencer for the EEG classification path: streams overlapping sample windows
// from a 1-cycle-latency BRAM to the feature pipeline and collects one label per window.
module bci_window_sequencer #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 21,
    parameter int LABEL_W     = 4,
    parameter int WIN_LEN     = 250,
    parameter int HOP         = 125,
    parameter int NUM_WINDOWS = 9745,
    parameter int TIMEOUT     = 4096
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    output logic               o_mem_en,
    output logic [ADDR_W-1:0]  o_mem_addr,
    input  logic [DATA_W-1:0]  i_mem_data,
    output logic               o_smp_valid,
    output logic [DATA_W-1:0]  o_smp_data,
    output logic               o_smp_last,
    input  logic               i_smp_ready,
    input  logic               i_cls_valid,
    input  logic [LABEL_W-1:0] i_cls_label,
    output logic [LABEL_W-1:0] class_label,
    output logic               done,
    output logic               o_timeout,
    output logic               o_finished
);

    localparam int IDX_W = $clog2(WIN_LEN);
    localparam int CNT_W = $clog2(NUM_WINDOWS + 1);
    localparam int WD_W  = $clog2(TIMEOUT);

    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WIN_LEN - 1);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(NUM_WINDOWS);
    localparam logic [ADDR_W-1:0] HOP_A    = ADDR_W'(HOP);

    localparam longint unsigned SPAN =
        longint'(NUM_WINDOWS - 1) * longint'(HOP) + longint'(WIN_LEN);
    localparam longint unsigned MEM_SIZE = 64'd1 << ADDR_W;

    // Parameter sanity: the last window must fit the address space, so no wrap is possible.
    if (SPAN > MEM_SIZE) begin : g_span_check
        $error("bci_window_sequencer: windows exceed the sample address space");
    end
    if (WIN_LEN < 2 || HOP < 1 || HOP > WIN_LEN || TIMEOUT < 2 || NUM_WINDOWS < 1) begin : g_param_check
        $error("bci_window_sequencer: illegal WIN_LEN/HOP/TIMEOUT/NUM_WINDOWS");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_SEND,
        S_WAIT_CLS,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t               state_reg,    state_next;
    logic [ADDR_W-1:0]    win_base_reg, win_base_next;
    logic [IDX_W-1:0]     idx_reg,      idx_next;
    logic [CNT_W-1:0]     win_cnt_reg,  win_cnt_next;
    logic [WD_W-1:0]      wd_cnt_reg,   wd_cnt_next;
    logic [ADDR_W-1:0]    mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]    smp_data_reg, smp_data_next;
    logic [LABEL_W-1:0]   label_reg,    label_next;
    logic                 timeout_reg,  timeout_next;
    logic                 finished_reg, finished_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= S_IDLE;
            win_base_reg <= '0;
            idx_reg      <= '0;
            win_cnt_reg  <= '0;
            wd_cnt_reg   <= '0;
            mem_addr_reg <= '0;
            smp_data_reg <= '0;
            label_reg    <= '0;
            timeout_reg  <= 1'b0;
            finished_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            win_base_reg <= win_base_next;
            idx_reg      <= idx_next;
            win_cnt_reg  <= win_cnt_next;
            wd_cnt_reg   <= wd_cnt_next;
            mem_addr_reg <= mem_addr_next;
            smp_data_reg <= smp_data_next;
            label_reg    <= label_next;
            timeout_reg  <= timeout_next;
            finished_reg <= finished_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        win_base_next = win_base_reg;
        idx_next      = idx_reg;
        win_cnt_next  = win_cnt_reg;
        wd_cnt_next   = wd_cnt_reg;
        mem_addr_next = mem_addr_reg;
        smp_data_next = smp_data_reg;
        label_next    = label_reg;
        timeout_next  = timeout_reg;
        finished_next = finished_reg;
        o_mem_en      = 1'b0;
        o_smp_valid   = 1'b0;
        o_smp_last    = 1'b0;
        done          = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (i_enable) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                // Pausing here means no read is in flight, so resume needs no replay.
                o_mem_en = i_enable;
                if (i_enable) begin
                    state_next = S_LATCH;
                end
            end
            S_LATCH: begin
                smp_data_next = i_mem_data;
                state_next    = S_SEND;
            end
            S_SEND: begin
                o_smp_valid = 1'b1;
                o_smp_last  = (idx_reg == IDX_LAST);
                if (i_smp_ready) begin
                    if (idx_reg == IDX_LAST) begin
                        idx_next    = '0;
                        wd_cnt_next = '0;
                        state_next  = S_WAIT_CLS;
                    end else begin
                        idx_next      = idx_reg + 1'b1;
                        mem_addr_next = win_base_reg + ADDR_W'(idx_next);
                        state_next    = S_FETCH;
                    end
                end
            end
            S_WAIT_CLS: begin
                wd_cnt_next = wd_cnt_reg + 1'b1;
                // A result arriving on the expiry cycle still counts as an answer.
                if (i_cls_valid) begin
                    label_next = i_cls_label;
                    state_next = S_EMIT;
                end else if (wd_cnt_reg == WD_LAST) begin
                    label_next   = '1;
                    timeout_next = 1'b1;
                    state_next   = S_EMIT;
                end
            end
            S_EMIT: begin
                done          = 1'b1;
                win_cnt_next  = win_cnt_reg + 1'b1;
                win_base_next = win_base_reg + HOP_A;
                if (win_cnt_next == CNT_DONE) begin
                    finished_next = 1'b1;
                    state_next    = S_FINISH;
                end else begin
                    mem_addr_next = win_base_next;
                    state_next    = S_FETCH;
                end
            end
            S_FINISH: begin
                state_next = S_FINISH;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign o_mem_addr  = mem_addr_reg;
    assign o_smp_data  = smp_data_reg;
    assign class_label = label_reg;
    assign o_timeout   = timeout_reg;
    assign o_finished  = finished_reg;

endmodule
